// File: rtl/urd_rx_fd_job_queue.sv
// rtl/urd_rx_fd_job_queue.sv - frame-descriptor job queue with slot-reservation availability flags
// Optional statistics counters are enabled by defining URD_FDQ_STATS_EN.
module urd_rx_fd_job_queue #(
    parameter int DEPTH = 8,
    parameter int LEN_W = 14,
    parameter int ERR_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             slot_reserve,
    input  logic             wr_job,
    input  logic             wr_err_job,
    input  logic [LEN_W-1:0] wr_len,
    input  logic             wr_concat,
    input  logic [ERR_W-1:0] wr_err_id,
    output logic             fd_valid,
    input  logic             fd_ready,
    output logic [LEN_W-1:0] fd_len,
    output logic             fd_concat,
    output logic             fd_err,
    output logic [ERR_W-1:0] fd_err_id,
    output logic             processing_queue_slot_available,
    output logic             processing_queue_slot_available_early,
    output logic             overflow_err,
    output logic [15:0]      job_cnt,
    output logic [15:0]      err_job_cnt
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int EW = LEN_W + ERR_W + 2;

    logic [EW-1:0] r_mem [DEPTH];
    logic [PW-1:0] r_rptr;
    logic [PW-1:0] r_wptr;
    logic [CW-1:0] r_count;
    logic [CW-1:0] r_resv;
    logic          r_ovf;
    logic          r_avail;
    logic          r_avail_early;

    logic          w_push;
    logic          w_pop;
    logic          w_full;
    logic          w_acc;
    logic [CW-1:0] w_count_nxt;
    logic [CW-1:0] w_resv_nxt;
    logic [CW-1:0] w_free_nxt;
    logic [EW-1:0] w_wr_entry;
    logic [EW-1:0] w_head;

    assign w_push = wr_job | wr_err_job;
    assign w_pop  = fd_valid & fd_ready;
    assign w_full = (r_count == CW'(DEPTH));
    // At full, a same-cycle pop frees the slot the push lands in.
    assign w_acc  = w_push & (~w_full | w_pop);

    assign w_count_nxt = r_count + CW'(w_acc) - CW'(w_pop);
    assign w_free_nxt  = CW'(DEPTH) - w_count_nxt;

    always_comb begin
        w_resv_nxt = r_resv;
        if (slot_reserve && !w_acc) begin
            if (r_resv != CW'(DEPTH)) w_resv_nxt = r_resv + CW'(1);
        end else if (w_acc && !slot_reserve) begin
            if (r_resv != '0) w_resv_nxt = r_resv - CW'(1);
        end
    end

    assign w_wr_entry = {wr_len, wr_concat, wr_err_job,
                         (wr_err_job ? wr_err_id : {ERR_W{1'b0}})};

    always_ff @(posedge clk) begin
        if (w_acc) r_mem[r_wptr] <= w_wr_entry;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rptr        <= '0;
            r_wptr        <= '0;
            r_count       <= '0;
            r_resv        <= '0;
            r_ovf         <= 1'b0;
            r_avail       <= 1'b1;
            r_avail_early <= 1'b1;
        end else begin
            if (w_acc) r_wptr <= r_wptr + PW'(1);
            if (w_pop) r_rptr <= r_rptr + PW'(1);
            if (w_push && !w_acc) r_ovf <= 1'b1;
            r_count       <= w_count_nxt;
            r_resv        <= w_resv_nxt;
            r_avail       <= (w_free_nxt > w_resv_nxt);
            r_avail_early <= ({1'b0, w_free_nxt} >= ({1'b0, w_resv_nxt} + (CW+1)'(2)));
        end
    end

    assign w_head    = r_mem[r_rptr];
    assign fd_valid  = (r_count != '0);
    assign fd_len    = w_head[EW-1 -: LEN_W];
    assign fd_concat = w_head[ERR_W+1];
    assign fd_err    = w_head[ERR_W];
    assign fd_err_id = w_head[ERR_W-1:0];

    assign processing_queue_slot_available       = r_avail;
    assign processing_queue_slot_available_early = r_avail_early;
    assign overflow_err                          = r_ovf;

`ifdef URD_FDQ_STATS_EN
    logic [15:0] r_job_cnt;
    logic [15:0] r_err_job_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_job_cnt     <= '0;
            r_err_job_cnt <= '0;
        end else if (w_acc) begin
            r_job_cnt <= r_job_cnt + 16'd1;
            if (wr_err_job) r_err_job_cnt <= r_err_job_cnt + 16'd1;
        end
    end

    assign job_cnt     = r_job_cnt;
    assign err_job_cnt = r_err_job_cnt;
`else
    assign job_cnt     = 16'd0;
    assign err_job_cnt = 16'd0;
`endif

endmodule

// File: tb/tb_urd_rx_fd_job_queue.sv
// tb/tb_urd_rx_fd_job_queue.sv - directed and random checks of urd_rx_fd_job_queue against a queue model
module tb_urd_rx_fd_job_queue;

    localparam int DEPTH = 8;
    localparam int LEN_W = 14;
    localparam int ERR_W = 8;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             slot_reserve = 1'b0;
    logic             wr_job = 1'b0;
    logic             wr_err_job = 1'b0;
    logic [LEN_W-1:0] wr_len = '0;
    logic             wr_concat = 1'b0;
    logic [ERR_W-1:0] wr_err_id = '0;
    logic             fd_ready = 1'b0;
    logic             fd_valid;
    logic [LEN_W-1:0] fd_len;
    logic             fd_concat;
    logic             fd_err;
    logic [ERR_W-1:0] fd_err_id;
    logic             avail;
    logic             avail_early;
    logic             overflow_err;
    logic [15:0]      job_cnt;
    logic [15:0]      err_job_cnt;

    urd_rx_fd_job_queue #(.DEPTH(DEPTH), .LEN_W(LEN_W), .ERR_W(ERR_W)) dut (
        .clk                                   (clk),
        .rst                                   (rst),
        .slot_reserve                          (slot_reserve),
        .wr_job                                (wr_job),
        .wr_err_job                            (wr_err_job),
        .wr_len                                (wr_len),
        .wr_concat                             (wr_concat),
        .wr_err_id                             (wr_err_id),
        .fd_valid                              (fd_valid),
        .fd_ready                              (fd_ready),
        .fd_len                                (fd_len),
        .fd_concat                             (fd_concat),
        .fd_err                                (fd_err),
        .fd_err_id                             (fd_err_id),
        .processing_queue_slot_available       (avail),
        .processing_queue_slot_available_early (avail_early),
        .overflow_err                          (overflow_err),
        .job_cnt                               (job_cnt),
        .err_job_cnt                           (err_job_cnt)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [LEN_W-1:0] len;
        logic             cc;
        logic             err;
        logic [ERR_W-1:0] id;
    } ent_t;

    ent_t        m_q[$];
    int          m_resv = 0;
    logic        m_ovf = 1'b0;
    logic [15:0] m_jobs = '0;
    logic [15:0] m_errs = '0;
    int          total = 0;
    int          bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_resv = 0;
        m_ovf  = 1'b0;
        m_jobs = '0;
        m_errs = '0;
    endtask

    task automatic check_all(input string tag);
        int free;
        free = DEPTH - m_q.size();
        chk({tag, ".fd_valid"}, 32'(fd_valid), 32'(m_q.size() > 0));
        if (m_q.size() > 0) begin
            chk({tag, ".fd_len"},    32'(fd_len),    32'(m_q[0].len));
            chk({tag, ".fd_concat"}, 32'(fd_concat), 32'(m_q[0].cc));
            chk({tag, ".fd_err"},    32'(fd_err),    32'(m_q[0].err));
            chk({tag, ".fd_err_id"}, 32'(fd_err_id), 32'(m_q[0].id));
        end
        chk({tag, ".avail"},    32'(avail),        32'((free - m_resv) >= 1));
        chk({tag, ".early"},    32'(avail_early),  32'((free - m_resv) >= 2));
        chk({tag, ".overflow"}, 32'(overflow_err), 32'(m_ovf));
`ifdef URD_FDQ_STATS_EN
        chk({tag, ".job_cnt"},     32'(job_cnt),     32'(m_jobs));
        chk({tag, ".err_job_cnt"}, 32'(err_job_cnt), 32'(m_errs));
`else
        chk({tag, ".job_cnt"},     32'(job_cnt),     32'd0);
        chk({tag, ".err_job_cnt"}, 32'(err_job_cnt), 32'd0);
`endif
    endtask

    // One clock: drive, let the edge happen, advance the model, then compare.
    task automatic cyc(input string tag, input logic res, input logic wj, input logic we,
                       input logic [LEN_W-1:0] len, input logic cc,
                       input logic [ERR_W-1:0] id, input logic rdy);
        logic push, pop, acc;
        ent_t e;
        slot_reserve = res;
        wr_job       = wj;
        wr_err_job   = we;
        wr_len       = len;
        wr_concat    = cc;
        wr_err_id    = id;
        fd_ready     = rdy;
        @(posedge clk);
        push = wj | we;
        pop  = (m_q.size() > 0) && rdy;
        acc  = push && ((m_q.size() < DEPTH) || pop);
        if (pop) void'(m_q.pop_front());
        if (acc) begin
            e.len = len;
            e.cc  = cc;
            e.err = we;
            e.id  = we ? id : '0;
            m_q.push_back(e);
            m_jobs = m_jobs + 16'd1;
            if (we) m_errs = m_errs + 16'd1;
        end
        if (push && !acc) m_ovf = 1'b1;
        if (res && !acc) begin
            if (m_resv < DEPTH) m_resv++;
        end else if (acc && !res) begin
            if (m_resv > 0) m_resv--;
        end
        #1;
        check_all(tag);
    endtask

    task automatic idle(input string tag, input logic rdy);
        cyc(tag, 1'b0, 1'b0, 1'b0, '0, 1'b0, '0, rdy);
    endtask

    task automatic push_n(input string tag, input int n, input logic rdy);
        for (int i = 0; i < n; i++)
            cyc(tag, 1'b0, 1'b1, 1'b0, LEN_W'(16'h100 + i), i[0], 8'hFF, rdy);
    endtask

    initial begin
        ent_t head;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        model_reset();
        check_all("reset");
        chk("reset.fd_valid_const", 32'(fd_valid), 32'd0);
        chk("reset.avail_const", 32'({avail, avail_early}), 32'd3);

        // single job, latency and pop
        cyc("single", 1'b0, 1'b1, 1'b0, 14'h040, 1'b0, 8'h55, 1'b0);
        chk("single.len_const", 32'(fd_len), 32'h40);
        chk("single.err_id_const", 32'(fd_err_id), 32'h0);
        idle("single_pop", 1'b1);
        chk("single.empty_const", 32'(fd_valid), 32'd0);

        // both triggers together form one error entry
        cyc("errprio", 1'b0, 1'b1, 1'b1, 14'h123, 1'b1, 8'h21, 1'b0);
        chk("errprio.err_const", 32'({fd_err, fd_err_id}), 32'h121);
        idle("errprio_pop", 1'b1);
        idle("errprio_empty", 1'b0);

        // reservation accounting
        push_n("resv_fill", 6, 1'b0);
        cyc("resv1", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("resv1.const", 32'({avail, avail_early}), 32'h2);
        cyc("resv2", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        chk("resv2.const", 32'({avail, avail_early}), 32'h0);
        idle("resv_pop", 1'b1);
        chk("resv_pop.const", 32'(avail), 32'd1);

        // full boundary, drop, push+pop at full, ordered drain
        push_n("full_fill", 3, 1'b0);
        head = m_q[0];
        cyc("drop", 1'b0, 1'b1, 1'b0, 14'h3FFF, 1'b1, '0, 1'b0);
        chk("drop.ovf_const", 32'(overflow_err), 32'd1);
        chk("drop.head", 32'(fd_len), 32'(head.len));
        cyc("full_pp", 1'b0, 1'b1, 1'b0, 14'h2AA, 1'b1, '0, 1'b1);
        chk("full_pp.count", 32'(m_q.size()), 32'(DEPTH));
        for (int i = 0; i < DEPTH + 1; i++) idle("drain", 1'b1);

        // mid-operation asynchronous reset
        push_n("mid_fill", 3, 1'b0);
        cyc("mid_r1", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        cyc("mid_r2", 1'b1, 1'b0, 1'b0, '0, 1'b0, '0, 1'b0);
        #2 rst = 1'b1;
        #1 model_reset();
        check_all("midrst");
        chk("midrst.const", 32'({fd_valid, avail, avail_early}), 32'h3);
        #2 rst = 1'b0;
        cyc("post_rst_push", 1'b0, 1'b1, 1'b0, 14'h0AB, 1'b0, '0, 1'b0);
        chk("post_rst_push.const", 32'(fd_valid), 32'd1);

        // randomized traffic, first biased toward filling, then draining
        for (int i = 0; i < 600; i++) begin
            cyc("rand", ($urandom_range(0, 3) == 0), ($urandom_range(0, 2) == 0),
                ($urandom_range(0, 4) == 0), LEN_W'($urandom), 1'($urandom),
                ERR_W'($urandom), ($urandom_range(0, 9) < ((i < 300) ? 3 : 7)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/urd_rx_fd_job_queue.md
# urd_rx_fd_job_queue

Frame-descriptor job queue directly downstream of the URD RX frame-decode controller. Captures one descriptor per `trigger_write_fd_job_queue` / `trigger_write_fd_job_queue_error_job` pulse, buffers descriptors in a synchronous FIFO and presents them to the descriptor writer over a valid/ready handshake. It also generates the controller's `processing_queue_slot_available` and `processing_queue_slot_available_early` inputs from occupancy plus outstanding slot reservations.

## Interface

Parameters:
- `DEPTH`, 8: descriptor entries; power of two, ≥ 4.
- `LEN_W`, 14: frame length field width.
- `ERR_W`, 8: error-id field width.

Ports:
- `clk`  in  1  clock; all logic on the rising edge.
- `rst`  in  1  reset. One clock domain; `rst` is asynchronous and active-high.
- `slot_reserve`  in  1  pulse; the controller has committed to a frame that will later write one descriptor.
- `wr_job`  in  1  `trigger_write_fd_job_queue`.
- `wr_err_job`  in  1  `trigger_write_fd_job_queue_error_job`.
- `wr_len`  in  `LEN_W`  frame length, sampled on write.
- `wr_concat`  in  1  concatenate flag, sampled on write.
- `wr_err_id`  in  `ERR_W`  error id; stored only for error jobs, otherwise stored as 0.
- `fd_valid`  out  1  head entry valid.
- `fd_ready`  in  1  consumer accepts head.
- `fd_len` / `fd_concat` / `fd_err` / `fd_err_id`  out  `LEN_W` / 1 / 1 / `ERR_W`  head entry fields.
- `processing_queue_slot_available`  out  1  free − reserved ≥ 1.
- `processing_queue_slot_available_early`  out  1  free − reserved ≥ 2.
- `overflow_err`  out  1  sticky; a write was dropped.
- `job_cnt` / `err_job_cnt`  out  16 / 16  statistics (see Configuration).

## Operation

- Storage: `DEPTH`-entry register array; read pointer, write pointer and `count` (width clog2(DEPTH)+1). Pointers wrap modulo `DEPTH`.
- Push = `wr_job | wr_err_job`. If both are high, one entry is written with `fd_err=1`. The push is accepted when `count < DEPTH`, or when `count == DEPTH` and a pop occurs in the same cycle.
- Pop = `fd_valid & fd_ready`. `fd_*` fields show the head entry combinationally from the array. When `fd_valid=0`, the field values are don't-care but must be stable.
- Dropped push (full, no pop): no state change, except `overflow_err` sets to 1 and stays set until `rst`.
- Reservation counter `resv` (range 0..`DEPTH`):
  - +1 on `slot_reserve`; −1 on an accepted push.
  - Both in the same cycle: unchanged.
  - Decrement saturates at 0, so a push without a reservation is legal.
  - Increment saturates at `DEPTH`.
- `free = DEPTH − count`. Availability outputs are registered from next-state `count` and `resv`. They therefore reflect the cycle's push, pop and reserve one cycle later, with no combinational path from inputs.
- An entry stays in the array until popped; `fd_ready` has no effect while `fd_valid=0`.

## Timing

- Reset values:
  - Pointers, `count`, `resv`, `overflow_err`, `fd_valid`, `job_cnt`, `err_job_cnt` = 0.
  - `processing_queue_slot_available` = 1; `processing_queue_slot_available_early` = 1.
- Write-to-valid latency: push in cycle N gives `fd_valid=1` in N+1 when the queue was empty. There is no same-cycle bypass.
- Pop in cycle N: the next entry is presented in N+1; throughput is one push and one pop per cycle.
- Simultaneous push and pop at `count==DEPTH`: both are accepted and `count` stays `DEPTH`.
- Simultaneous push and pop at `count==0`: the pop is impossible (`fd_valid=0`) and only the push takes effect.
- Asserting `rst` mid-operation discards all entries and reservations immediately (asynchronous). The first push is accepted on the first edge after `rst` deasserts.

## Configuration

- `URD_FDQ_STATS_EN` defined:
  - `job_cnt` increments on every accepted push.
  - `err_job_cnt` increments on every accepted push with `fd_err=1`.
  - Both are 16-bit, wrap from 0xFFFF to 0, and clear on `rst`.
- Not defined: counter logic is omitted and `job_cnt` / `err_job_cnt` are tied to 0.

## Test plan

- Reset with DEPTH=8: after `rst` release, `fd_valid=0`, both slot_available outputs = 1 and `overflow_err=0`.
- Single normal job: `wr_job=1`, `wr_len=0x040`, `wr_concat=0` in cycle N → in N+1 `fd_valid=1`, `fd_len=0x040`, `fd_err=0`, `fd_err_id=0`. With `fd_ready=1` in N+1, `fd_valid=0` in N+2.
- Error-job priority: `wr_job=1`, `wr_err_job=1`, `wr_err_id=0x21` → exactly one entry with `fd_err=1` and `fd_err_id=0x21`; `err_job_cnt=1` with `URD_FDQ_STATS_EN`, otherwise 0.
- Reservation accounting: 6 pushes held (`fd_ready=0`) plus 1 `slot_reserve` → `slot_available=1`, `early=0`. A further `slot_reserve` → both 0 on the next cycle. One pop → `slot_available=1`.
- Full boundary: 8 pushes, `fd_ready=0`. A 9th push is dropped, `overflow_err=1`, and the head entry is unchanged. A push and pop in the same cycle at full → both accepted, `count` stays 8, and FIFO order is preserved.
- Mid-operation reset: 3 entries and 2 reservations, then a 1-cycle `rst` pulse → `fd_valid=0` and both availability outputs = 1 immediately after reset.
